usb_reg_bus_master: RTL and testbench

Bridges the host's asynchronous 8-bit parallel bus (address latch, read and write strobes) onto the internal register bus consumed by all register blocks, including the ADC FIFO register block. Strobes are synchronized into clk_usb. Each host strobe becomes a single register-bus transaction. reg_bytecnt auto-increments so that multi-byte registers and FIFO bursts stream byte by byte. The block sits between the top-level USB pins and the register-bus fan-out and mux.

---
 rtl/usb_reg_bus_master.sv | 215 +++++++++++++++++++++
 tb/tb_usb_reg_bus_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_reg_bus_master.sv
// -----------------------------------------------------------------------------
// usb_reg_bus_master
//
// Bridges the host's asynchronous 8-bit parallel bus (address latch, read and
// write strobes) onto the internal register bus. Every host strobe becomes one
// register-bus transaction, and reg_bytecnt advances once per completed byte
// so that multi-byte registers and FIFO bursts stream byte by byte.
//
// Ports
//   clk_usb      : clock, rising edge
//   reset        : synchronous, active-high
//   usb_addr     : host register address, sampled while alen is low
//   usb_din      : host write data, sampled on the write strobe
//   usb_dout     : read data to the pins
//   usb_isout    : pad output enable while a read is served
//   usb_cen      : chip enable, active-low, asynchronous
//   usb_alen     : address latch enable, active-low, asynchronous
//   usb_rdn      : read strobe, active-low, asynchronous
//   usb_wrn      : write strobe, active-low, asynchronous
//   reg_address  : latched register address
//   reg_bytecnt  : byte index within the current register access
//   reg_datai    : write data for register blocks
//   reg_datao    : combinational read data from the register mux
//   reg_read     : level, high for one host read byte
//   reg_write    : single-cycle pulse per host write byte
//   bus_error    : sticky, rdn and wrn seen low together
// -----------------------------------------------------------------------------
module usb_reg_bus_master #(
   parameter int pBYTECNT_SIZE = 7
) (
   input  logic                     clk_usb,
   input  logic                     reset,
   input  logic [7:0]               usb_addr,
   input  logic [7:0]               usb_din,
   output logic [7:0]               usb_dout,
   output logic                     usb_isout,
   input  logic                     usb_cen,
   input  logic                     usb_alen,
   input  logic                     usb_rdn,
   input  logic                     usb_wrn,
   output logic [7:0]               reg_address,
   output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
   output logic [7:0]               reg_datai,
   input  logic [7:0]               reg_datao,
   output logic                     reg_read,
   output logic                     reg_write,
   output logic                     bus_error
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_HOLD  = 2'd1,
      RD_SETUP = 2'd2,
      RD_HOLD  = 2'd3
   } state_t;

   localparam logic [pBYTECNT_SIZE-1:0] CNT_ONE = {{(pBYTECNT_SIZE-1){1'b0}}, 1'b1};

   // Level-only controls need two stages; strobes get a third for edge detect.
   logic [1:0] cen_sync_q, alen_sync_q;
   logic [2:0] rdn_sync_q, wrn_sync_q;
   // After reset the synchronizers are forced high, so a strobe already held
   // low at the pin would look like a fresh falling edge. settle_q marks when
   // the pipeline reflects the pins again; block_q suppresses new transactions
   // until both strobes have been observed high.
   logic [1:0] settle_q;
   logic       block_q, block_d;

   state_t                     state_q, state_d;
   logic [7:0]                 address_q, address_d;
   logic [pBYTECNT_SIZE-1:0]   bytecnt_q, bytecnt_d;
   logic [7:0]                 datai_q, datai_d;
   logic [7:0]                 dout_q, dout_d;
   logic                       read_q, read_d;
   logic                       write_q, write_d;
   logic                       error_q, error_d;

   logic cen_s, alen_s, rdn_s, wrn_s;
   logic rdn_fall_s, wrn_fall_s, conflict_s;

   assign cen_s      = cen_sync_q[1];
   assign alen_s     = alen_sync_q[1];
   assign rdn_s      = rdn_sync_q[1];
   assign wrn_s      = wrn_sync_q[1];
   assign rdn_fall_s = ~rdn_sync_q[1] & rdn_sync_q[2];
   assign wrn_fall_s = ~wrn_sync_q[1] & wrn_sync_q[2];
   assign conflict_s = ~rdn_s & ~wrn_s;

   // Synchronizer chains and post-reset settle tracking.
   always_ff @(posedge clk_usb) begin
      if (reset) begin
         cen_sync_q  <= 2'b11;
         alen_sync_q <= 2'b11;
         rdn_sync_q  <= 3'b111;
         wrn_sync_q  <= 3'b111;
         settle_q    <= 2'b00;
      end else begin
         cen_sync_q  <= {cen_sync_q[0], usb_cen};
         alen_sync_q <= {alen_sync_q[0], usb_alen};
         rdn_sync_q  <= {rdn_sync_q[1:0], usb_rdn};
         wrn_sync_q  <= {wrn_sync_q[1:0], usb_wrn};
         settle_q    <= {settle_q[0], 1'b1};
      end
   end

   // Transaction state and bus output registers.
   always_ff @(posedge clk_usb) begin
      if (reset) begin
         state_q   <= IDLE;
         address_q <= 8'h00;
         bytecnt_q <= '0;
         datai_q   <= 8'h00;
         dout_q    <= 8'h00;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         error_q   <= 1'b0;
         block_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         address_q <= address_d;
         bytecnt_q <= bytecnt_d;
         datai_q   <= datai_d;
         dout_q    <= dout_d;
         read_q    <= read_d;
         write_q   <= write_d;
         error_q   <= error_d;
         block_q   <= block_d;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d   = state_q;
      address_d = address_q;
      bytecnt_d = bytecnt_q;
      datai_d   = datai_q;
      dout_d    = dout_q;
      read_d    = read_q;
      write_d   = 1'b0;
      error_d   = error_q;
      block_d   = block_q & ~(settle_q[1] & rdn_s & wrn_s);

      if (conflict_s) begin
         // Both strobes low: abandon whatever was in flight, no increment.
         error_d = 1'b1;
         read_d  = 1'b0;
         block_d = 1'b1;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (~alen_s) begin
                  address_d = usb_addr;
                  bytecnt_d = '0;
               end else if (~block_q & ~cen_s & wrn_fall_s) begin
                  datai_d = usb_din;
                  write_d = 1'b1;
                  state_d = WR_HOLD;
               end else if (~block_q & ~cen_s & rdn_fall_s) begin
                  read_d  = 1'b1;
                  state_d = RD_SETUP;
               end else begin
                  state_d = IDLE;
               end
            end
            WR_HOLD: begin
               if (cen_s) begin
                  state_d = IDLE;
               end else if (wrn_s) begin
                  bytecnt_d = bytecnt_q + CNT_ONE;
                  state_d   = IDLE;
               end else begin
                  state_d = WR_HOLD;
               end
            end
            RD_SETUP: begin
               // One settle cycle after reg_read rises before sampling the mux.
               if (cen_s) begin
                  read_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  dout_d  = reg_datao;
                  state_d = RD_HOLD;
               end
            end
            RD_HOLD: begin
               if (cen_s) begin
                  read_d  = 1'b0;
                  state_d = IDLE;
               end else if (rdn_s) begin
                  read_d    = 1'b0;
                  bytecnt_d = bytecnt_q + CNT_ONE;
                  state_d   = IDLE;
               end else begin
                  state_d = RD_HOLD;
               end
            end
            default: begin
               read_d  = 1'b0;
               state_d = IDLE;
            end
         endcase
      end
   end

   assign usb_isout   = ~rdn_s & ~cen_s & ((state_q == RD_SETUP) | (state_q == RD_HOLD));
   assign usb_dout    = dout_q;
   assign reg_address = address_q;
   assign reg_bytecnt = bytecnt_q;
   assign reg_datai   = datai_q;
   assign reg_read    = read_q;
   assign reg_write   = write_q;
   assign bus_error   = error_q;

endmodule

// File: tb/tb_usb_reg_bus_master.sv
// Testbench for usb_reg_bus_master: directed scenarios followed by randomized
// host traffic, checked against a byte-level model of the register bus.
module tb_usb_reg_bus_master;

   localparam int CW = 7;

   logic          clk_usb = 1'b0;
   logic          reset   = 1'b1;
   logic [7:0]    usb_addr = 8'h00;
   logic [7:0]    usb_din  = 8'h00;
   logic [7:0]    usb_dout;
   logic          usb_isout;
   logic          usb_cen  = 1'b1;
   logic          usb_alen = 1'b1;
   logic          usb_rdn  = 1'b1;
   logic          usb_wrn  = 1'b1;
   logic [7:0]    reg_address;
   logic [CW-1:0] reg_bytecnt;
   logic [7:0]    reg_datai;
   logic [7:0]    reg_datao;
   logic          reg_read;
   logic          reg_write;
   logic          bus_error;

   logic [7:0]    rd_base = 8'hA0;

   // Register mux stand-in: data depends on the byte index.
   assign reg_datao = rd_base + {1'b0, reg_bytecnt};

   always #5 clk_usb = ~clk_usb;

   usb_reg_bus_master #(.pBYTECNT_SIZE(CW)) dut (
      .clk_usb     (clk_usb),
      .reset       (reset),
      .usb_addr    (usb_addr),
      .usb_din     (usb_din),
      .usb_dout    (usb_dout),
      .usb_isout   (usb_isout),
      .usb_cen     (usb_cen),
      .usb_alen    (usb_alen),
      .usb_rdn     (usb_rdn),
      .usb_wrn     (usb_wrn),
      .reg_address (reg_address),
      .reg_bytecnt (reg_bytecnt),
      .reg_datai   (reg_datai),
      .reg_datao   (reg_datao),
      .reg_read    (reg_read),
      .reg_write   (reg_write),
      .bus_error   (bus_error)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: what the register bus should look like, byte by byte.
   logic [7:0]    m_addr  = 8'h00;
   logic [CW-1:0] m_cnt   = '0;
   logic [7:0]    m_wdata = 8'h00;
   logic          m_err   = 1'b0;

   // Bus monitor: records every write pulse and every reg_read rising edge.
   logic [22:0] wr_q[$];
   int          rd_rises  = 0;
   int          isout_bad = 0;
   logic        prev_read = 1'b0;
   logic [2:0]  rdn_hist  = 3'b111;

   always @(negedge clk_usb) begin
      if (reg_write) wr_q.push_back({reg_address, reg_bytecnt, reg_datai});
      if (reg_read && !prev_read) rd_rises <= rd_rises + 1;
      prev_read <= reg_read;
      rdn_hist  <= {rdn_hist[1:0], usb_rdn};
      if (usb_isout && rdn_hist == 3'b111) isout_bad <= isout_bad + 1;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk_usb);
   endtask

   task automatic check_reset_vals(input string pfx);
      check_eq({pfx, "_addr"},  32'(reg_address), 32'h0);
      check_eq({pfx, "_cnt"},   32'(reg_bytecnt), 32'h0);
      check_eq({pfx, "_datai"}, 32'(reg_datai),   32'h0);
      check_eq({pfx, "_read"},  32'(reg_read),    32'h0);
      check_eq({pfx, "_write"}, 32'(reg_write),   32'h0);
      check_eq({pfx, "_dout"},  32'(usb_dout),    32'h0);
      check_eq({pfx, "_isout"}, 32'(usb_isout),   32'h0);
      check_eq({pfx, "_err"},   32'(bus_error),   32'h0);
   endtask

   task automatic latch(input logic [7:0] a);
      #1 usb_addr = a; usb_alen = 1'b0;
      step(4);
      #1 usb_alen = 1'b1;
      step(3);
      m_addr = a;
      m_cnt  = '0;
      check_eq("latch_addr", 32'(reg_address), 32'(m_addr));
      check_eq("latch_cnt",  32'(reg_bytecnt), 32'(m_cnt));
   endtask

   task automatic wr_byte(input logic [7:0] d, input int lo, input int hi);
      logic [22:0] rec;
      #1 usb_din = d; usb_wrn = 1'b0;
      step(lo);
      #1 usb_wrn = 1'b1;
      step(hi);
      check_eq("wr_count", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) begin
         rec = wr_q.pop_front();
         check_eq("wr_rec", 32'(rec), 32'({m_addr, m_cnt, d}));
      end
      wr_q.delete();
      m_wdata = d;
      m_cnt   = m_cnt + 7'd1;
      check_eq("wr_bytecnt", 32'(reg_bytecnt), 32'(m_cnt));
   endtask

   task automatic rd_byte(input int lo, input int hi);
      int         r0;
      logic [7:0] exp_d;
      r0    = rd_rises;
      exp_d = rd_base + {1'b0, m_cnt};
      #1 usb_rdn = 1'b0;
      step(5);
      check_eq("rd_read_hi", 32'(reg_read),  32'd1);
      check_eq("rd_isout",   32'(usb_isout), 32'd1);
      check_eq("rd_dout",    32'(usb_dout),  32'(exp_d));
      check_eq("rd_datai",   32'(reg_datai), 32'(m_wdata));
      step(lo - 5);
      #1 usb_rdn = 1'b1;
      step(hi);
      m_cnt = m_cnt + 7'd1;
      check_eq("rd_read_lo", 32'(reg_read),      32'd0);
      check_eq("rd_rises",   32'(rd_rises - r0), 32'd1);
      check_eq("rd_bytecnt", 32'(reg_bytecnt),   32'(m_cnt));
      check_eq("rd_no_wr",   32'(wr_q.size()),   32'd0);
   endtask

   initial begin
      logic [22:0] rec;
      int          r0;
      int          op;

      // Reset state
      step(4);
      check_reset_vals("rst");
      #1 reset = 1'b0;
      step(3);
      #1 usb_cen = 1'b0;
      step(3);

      // 4-byte write burst to 0x2A
      latch(8'h2A);
      wr_byte(8'h11, 4, 4);
      wr_byte(8'h22, 4, 4);
      wr_byte(8'h33, 4, 4);
      wr_byte(8'h44, 4, 4);
      check_eq("burst_final_cnt", 32'(reg_bytecnt), 32'd4);

      // 3-byte read at 0x10
      latch(8'h10);
      rd_base = 8'hA0;
      r0 = rd_rises;
      for (int i = 0; i < 3; i++) rd_byte(6, 4);
      check_eq("rd3_rises", 32'(rd_rises - r0), 32'd3);

      // Byte counter wrap over 130 writes
      latch(8'($urandom));
      for (int i = 0; i < 130; i++) wr_byte(8'($urandom), 4, 4);
      check_eq("wrap_cnt", 32'(reg_bytecnt), 32'd2);

      // Chip enable dropped mid-read
      latch(8'h33);
      rd_base = 8'($urandom);
      rd_byte(6, 4);
      r0 = rd_rises;
      #1 usb_rdn = 1'b0;
      step(5);
      check_eq("abort_read_hi", 32'(reg_read), 32'd1);
      #1 usb_cen = 1'b1;
      step(3);
      check_eq("abort_read_lo", 32'(reg_read),    32'd0);
      check_eq("abort_cnt",     32'(reg_bytecnt), 32'(m_cnt));
      #1 usb_rdn = 1'b1;
      step(4);
      #1 usb_cen = 1'b0;
      step(4);
      check_eq("abort_cnt_after", 32'(reg_bytecnt),   32'(m_cnt));
      check_eq("abort_rises",     32'(rd_rises - r0), 32'd1);
      rd_byte(6, 4);

      // Strobe conflict
      #1 usb_rdn = 1'b0; usb_wrn = 1'b0;
      step(5);
      m_err = 1'b1;
      check_eq("conf_err",   32'(bus_error),    32'(m_err));
      check_eq("conf_read",  32'(reg_read),     32'd0);
      check_eq("conf_no_wr", 32'(wr_q.size()),  32'd0);
      check_eq("conf_cnt",   32'(reg_bytecnt),  32'(m_cnt));
      #1 usb_rdn = 1'b1; usb_wrn = 1'b1;
      step(4);
      wr_byte(8'h5A, 5, 4);
      rd_byte(7, 5);
      check_eq("conf_sticky", 32'(bus_error), 32'(m_err));

      // Reset while in WR_HOLD
      #1 usb_din = 8'hC3; usb_wrn = 1'b0;
      step(5);
      check_eq("rstw_count", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) begin
         rec = wr_q.pop_front();
         check_eq("rstw_rec", 32'(rec), 32'({m_addr, m_cnt, 8'hC3}));
      end
      wr_q.delete();
      #1 reset = 1'b1;
      step(1);
      check_reset_vals("rstw");
      #1 reset = 1'b0;
      m_addr = 8'h00; m_cnt = '0; m_wdata = 8'h00; m_err = 1'b0;
      step(3);
      #1 usb_wrn = 1'b1;
      step(6);
      check_eq("rstw_cnt_after", 32'(reg_bytecnt), 32'd0);
      check_eq("rstw_no_wr",     32'(wr_q.size()),  32'd0);

      // Randomized host traffic
      for (int i = 0; i < 80; i++) begin
         op = int'($urandom_range(0, 9));
         if (op == 0) begin
            latch(8'($urandom));
         end else if (op <= 5) begin
            wr_byte(8'($urandom), int'($urandom_range(4, 7)), int'($urandom_range(4, 6)));
         end else begin
            rd_base = 8'($urandom);
            rd_byte(int'($urandom_range(6, 9)), int'($urandom_range(4, 6)));
         end
      end
      check_eq("final_err",   32'(bus_error), 32'(m_err));
      check_eq("isout_bad",   32'(isout_bad), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
